// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor:
// FSM encodings, slice width and the nibble-counter width helper.
package nibble_serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int p = 1; p < value; p = p * 2) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/nibble_serial_addsub_rca4c.sv
// 4-bit ripple-carry adder slice with explicit carry-in, chained from
// single-bit full-adder cells.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca4c
   import nibble_serial_addsub_pkg::*;
(
   input  logic [NIBBLE-1:0] A,
   input  logic [NIBBLE-1:0] B,
   input  logic              Cin,
   output logic [NIBBLE-1:0] Sum,
   output logic              Cout
);
   logic [NIBBLE:0] carry;

   assign carry[0] = Cin;

   generate
      for (genvar gi = 0; gi < NIBBLE; gi++) begin : g_bit
         fa u_fa (
            .a    (A[gi]),
            .b    (B[gi]),
            .cin  (carry[gi]),
            .s    (Sum[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   assign Cout = carry[NIBBLE];
endmodule

// File: rtl/nibble_serial_addsub.sv
// Digit-serial W-bit adder/subtractor: one 4-bit slice reused per cycle,
// least-significant nibble first, result shifted in from the top.
module nibble_serial_addsub
   import nibble_serial_addsub_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Subtract,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] Sum,
   output logic         Cout,
   output logic         Overflow
);
   localparam int NNIB = W / NIBBLE;
   localparam int CW   = clog2(NNIB);
   localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q;
   logic [W-1:0]        a_sr_q, b_sr_q, sum_q;
   logic                sub_q, carry_q, cout_q, ovf_q;

   logic                accept, last_nib;
   logic [NIBBLE-1:0]   slice_b, slice_sum;
   logic                slice_cout;

   assign accept   = start && (state_q == IDLE || state_q == DONE);
   assign last_nib = (cnt_q == LAST);

   // Subtract is folded into the B operand here; the slice only ever adds.
   assign slice_b = b_sr_q[NIBBLE-1:0] ^ {NIBBLE{sub_q}};

   rca4c u_slice (
      .A    (a_sr_q[NIBBLE-1:0]),
      .B    (slice_b),
      .Cin  (carry_q),
      .Sum  (slice_sum),
      .Cout (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_nib) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         sum_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         cnt_q   <= '0;
         a_sr_q  <= A;
         b_sr_q  <= B;
         sub_q   <= Subtract;
         carry_q <= Subtract;
      end else if (state_q == RUN) begin
         sum_q   <= {slice_sum, sum_q[W-1:NIBBLE]};
         carry_q <= slice_cout;
         a_sr_q  <= a_sr_q >> NIBBLE;
         b_sr_q  <= b_sr_q >> NIBBLE;
         cnt_q   <= cnt_q + 1'b1;
         if (last_nib) begin
            cout_q <= slice_cout;
            // carry into the MSB xor carry out of the MSB
            ovf_q  <= a_sr_q[NIBBLE-1] ^ slice_b[NIBBLE-1] ^ slice_sum[NIBBLE-1] ^ slice_cout;
         end
      end
   end

   assign Sum      = sum_q;
   assign Cout     = cout_q;
   assign Overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub (W=16): expected {Sum,Cout,Overflow}
// is queued at launch and compared when done pulses.
module tb_nibble_serial_addsub;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset, start, Subtract;
   logic [W-1:0] A, B;
   logic         busy, done, Cout, Overflow;
   logic [W-1:0] Sum;

   int tests = 0;
   int fails = 0;
   logic [W+1:0] exp_q[$];

   nibble_serial_addsub #(.W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Subtract(Subtract),
      .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W+1:0] exp;
   } vec_t;

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic [W-1:0] bb;
      logic [W:0]   r;
      logic         ovf;
      bb  = sub ? ~b : b;
      r   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
      ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      return {r[W-1:0], r[W], ovf};
   endfunction

   function automatic logic [W+1:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic hold, input logic [W+1:0] exp);
      A = a; B = b; Subtract = sub; start = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = busy ? 1 : 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (busy) bcyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; A = '0; B = '0; Subtract = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({busy, done} !== 2'b00) begin
         fails++; $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done});
      end
      tests++;
      if ({Sum, Cout, Overflow} !== '0) begin
         fails++; $display("FAIL reset_outputs: got %h expected 0", {Sum, Cout, Overflow});
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      int cyc, bcyc;
      logic [W+1:0] exp;
      launch(16'h1234, 16'h1111, 1'b0, 1'b0, {16'h2345, 1'b0, 1'b0});
      wait_done(cyc, bcyc);
      tests++;
      if (cyc != 4) begin fails++; $display("FAIL add_latency: got %0d expected 4", cyc); end
      tests++;
      if (bcyc != 4) begin fails++; $display("FAIL add_busy_cycles: got %0d expected 4", bcyc); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL add_busy_with_done: busy=%b expected 0", busy); end
      exp = pop_exp();
      tests++;
      if ({Sum, Cout, Overflow} !== exp) begin
         fails++; $display("FAIL add_result: got %h expected %h", {Sum, Cout, Overflow}, exp);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || Sum !== 16'h2345) begin
         fails++; $display("FAIL add_pulse_hold: done=%b Sum=%h expected done=0 Sum=2345", done, Sum);
      end
   endtask

   task automatic test_vectors();
      vec_t tbl [5];
      int cyc, bcyc;
      logic [W+1:0] exp;
      tbl[0] = {16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = {16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[2] = {16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
      tbl[3] = {16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[4] = {16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         launch(tbl[i].a, tbl[i].b, tbl[i].sub, 1'b0, tbl[i].exp);
         wait_done(cyc, bcyc);
         exp = pop_exp();
         tests++;
         if (cyc != 4 || {Sum, Cout, Overflow} !== exp) begin
            fails++;
            $display("FAIL vector%0d: cyc=%0d got %h expected cyc=4 %h", i, cyc, {Sum, Cout, Overflow}, exp);
         end
      end
   endtask

   task automatic test_start_during_run();
      int cyc, bcyc;
      logic [W+1:0] exp;
      launch(16'h1234, 16'h0F0F, 1'b0, 1'b0, {16'h2143, 1'b0, 1'b0});
      @(posedge clk); #1;
      start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Subtract = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc, bcyc);
      exp = pop_exp();
      tests++;
      if (cyc != 2 || {Sum, Cout, Overflow} !== exp) begin
         fails++; $display("FAIL start_in_run: cyc=%0d got %h expected cyc=2 %h", cyc, {Sum, Cout, Overflow}, exp);
      end
      @(posedge clk); #1;
      tests++;
      if ({busy, done} !== 2'b00) begin
         fails++; $display("FAIL start_in_run_idle: busy/done=%b expected 00", {busy, done});
      end
   endtask

   task automatic test_operand_change();
      int cyc, bcyc;
      logic [W+1:0] exp;
      launch(16'hABCD, 16'h1234, 1'b1, 1'b0, {16'h9999, 1'b1, 1'b0});
      repeat (2) begin
         A = W'($urandom); B = W'($urandom); Subtract = 1'($urandom);
         @(posedge clk); #1;
      end
      wait_done(cyc, bcyc);
      exp = pop_exp();
      tests++;
      if (cyc != 2 || {Sum, Cout, Overflow} !== exp) begin
         fails++; $display("FAIL operand_change: cyc=%0d got %h expected cyc=2 %h", cyc, {Sum, Cout, Overflow}, exp);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcyc;
      logic [W+1:0] exp;
      launch(16'h1111, 16'h2222, 1'b0, 1'b1, {16'h3333, 1'b0, 1'b0});
      wait_done(cyc, bcyc);
      exp = pop_exp();
      tests++;
      if (cyc != 4 || {Sum, Cout, Overflow} !== exp) begin
         fails++; $display("FAIL b2b_first: cyc=%0d got %h expected cyc=4 %h", cyc, {Sum, Cout, Overflow}, exp);
      end
      A = 16'h0100; B = 16'h0200; Subtract = 1'b0;
      exp_q.push_back({16'h0300, 1'b0, 1'b0});
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL b2b_no_idle: busy=%b expected 1", busy); end
      wait_done(cyc, bcyc);
      exp = pop_exp();
      tests++;
      if (cyc != 4 || {Sum, Cout, Overflow} !== exp) begin
         fails++; $display("FAIL b2b_second: cyc=%0d got %h expected cyc=4 %h", cyc, {Sum, Cout, Overflow}, exp);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, bcyc, seen;
      logic [W+1:0] exp;
      launch(16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 1'b1, 1'b1});
      wait_done(cyc, bcyc);
      exp = pop_exp();
      tests++;
      if ({Sum, Cout, Overflow} !== exp) begin
         fails++; $display("FAIL pre_reset_result: got %h expected %h", {Sum, Cout, Overflow}, exp);
      end
      launch(16'h4321, 16'h1234, 1'b0, 1'b0, {16'h5555, 1'b0, 1'b0});
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      tests++;
      if ({busy, done, Sum, Cout, Overflow} !== '0) begin
         fails++; $display("FAIL reset_mid_clear: busy=%b done=%b out=%h expected all 0", busy, done, {Sum, Cout, Overflow});
      end
      reset = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      tests++;
      if (seen != 0) begin fails++; $display("FAIL reset_mid_no_done: active cycles=%0d expected 0", seen); end
      launch(16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0});
      wait_done(cyc, bcyc);
      exp = pop_exp();
      tests++;
      if (cyc != 4 || {Sum, Cout, Overflow} !== exp) begin
         fails++; $display("FAIL post_reset: cyc=%0d got %h expected cyc=4 %h", cyc, {Sum, Cout, Overflow}, exp);
      end
   endtask

   task automatic test_random();
      int cyc, bcyc;
      logic [W-1:0] a, b;
      logic sub;
      logic [W+1:0] exp;
      for (int i = 0; i < 8; i++) begin
         a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
         launch(a, b, sub, 1'b0, model(a, b, sub));
         wait_done(cyc, bcyc);
         exp = pop_exp();
         tests++;
         if (cyc != 4 || {Sum, Cout, Overflow} !== exp) begin
            fails++;
            $display("FAIL random%0d: %h %s %h cyc=%0d got %h expected %h", i, a, sub ? "-" : "+", b, cyc,
                     {Sum, Cout, Overflow}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_vectors();
      test_start_during_run();
      test_operand_change();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Digit-serial W-bit adder/subtractor that sits directly upstream of the 4-bit ripple-carry adder/subtractor stage. It captures two W-bit operands and feeds them to a single 4-bit carry-in adder slice one nibble per clock, least-significant nibble first. Between nibbles it holds the carry in a flop and shifts the result into a W-bit register. It trades W/4 cycles of latency for one 4-bit slice of area and is used wherever operands are wider than the 4-bit datapath.

## Interface
Parameters:
- W, 16, operand width in bits; must be a multiple of 4 and ≥ 8.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is accepting.
- A  in  W  operand A; captured at the accepting edge.
- B  in  W  operand B; captured at the accepting edge.
- Subtract  in  1  0 = A+B, 1 = A−B (two's complement); captured with the operands.
- busy  out  1  high while nibbles are being processed.
- done  out  1  one-cycle pulse; Sum, Cout and Overflow are valid.
- Sum  out  W  result; held from done until the next accepted start.
- Cout  out  1  carry out of bit W−1. For subtract, 1 means no borrow (A ≥ B unsigned).
- Overflow  out  1  signed overflow of the W-bit result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → capture, go to RUN.
  - RUN: after W/4 nibble edges → DONE.
  - DONE: start=1 → capture, go to RUN; otherwise → IDLE.
- Capture:
  - Load the A and B shift registers.
  - Latch Subtract.
  - Set the carry flop to Subtract.
  - Clear the nibble counter.
- Each RUN edge processes one nibble:
  - The slice adds a = A_sr[3:0], b = B_sr[3:0] XOR {4{Subtract}}, cin = carry flop.
  - The 4-bit slice sum shifts into Sum from the top (Sum ← {slice_sum, Sum[W−1:4]}).
  - The carry flop takes the slice cout.
  - A_sr and B_sr shift right by 4.
  - The counter increments.
- On the last nibble edge:
  - Cout ← slice cout.
  - Overflow ← (a[3] ^ b[3] ^ slice_sum[3]) ^ slice cout, i.e. carry into MSB XOR carry out of MSB.
- Arithmetic is modulo 2^W. There is no saturation.
- start during RUN is ignored; no queuing.
- Operand inputs are ignored except at the accepting edge; they may change freely during RUN.
- Sum, Cout and Overflow change only during RUN. They are stable from done until the next capture plus one edge.
- Reset (any state, including mid-RUN):
  - Next state IDLE.
  - busy=0, done=0, Sum=0, Cout=0, Overflow=0.
  - Counter, carry flop and shift registers cleared.
  - The in-flight operation is abandoned with no done pulse.
- reset and start high on the same edge: reset wins.

## Timing
- Edge 0: start accepted. From edge 0, busy=1.
- Edges 1..W/4: nibbles 0..W/4−1 processed.
- After edge W/4: busy=0, done=1 for exactly one cycle.
- Latency from accepting edge to done visible: W/4 edges (4 for W=16).
- Throughput: start held high in DONE is accepted immediately, giving one result per W/4+1 cycles.
- busy and done are registered, derived from state only. They are never high together.
- The slice is combinational inside one cycle. The critical path is the carry flop → 4-bit ripple → carry flop.

## Structure
- Shared arithmetic package/include holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NIBBLE=4;
  - counter width function clog2(W/4).
- One sub-module, rca4c: 4-bit ripple-carry adder with explicit Cin, built from the existing fa cell.
  - Ports: Sum[3:0], Cout, A[3:0], B[3:0], Cin.
  - The operand-B XOR for subtract sits in nibble_serial_addsub, not in the slice.
- Everything else is inline: FSM, counter, shift registers, carry/overflow flops.

## Test plan
All scenarios use W=16.
- Add: A=0x1234, B=0x1111, Subtract=0 → done on 4th edge after start; Sum=0x2345, Cout=0, Overflow=0; busy high exactly 4 cycles.
- Full carry chain: A=0xFFFF, B=0x0001, add → Sum=0x0000, Cout=1, Overflow=0.
- Subtract with borrow: A=0x0005, B=0x0007, Subtract=1 → Sum=0xFFFE, Cout=0, Overflow=0. A=0x0007, B=0x0005 → Sum=0x0002, Cout=1.
- Signed overflow:
  - A=0x7FFF + 0x0001 → Sum=0x8000, Overflow=1, Cout=0.
  - A=0x8000 − 0x0001 → Sum=0x7FFF, Overflow=1, Cout=1.
- Handshake:
  - start pulsed during RUN → ignored, result unchanged.
  - start held high through DONE → second operation (0x0100 + 0x0200 = 0x0300) begins with no IDLE cycle.
  - Operand inputs changed mid-RUN → result unaffected.
- Reset mid-operation: reset at 2nd RUN edge → next cycle busy=0, done=0, Sum=0, Cout=0, Overflow=0; no done pulse follows. A fresh start then yields a correct result (0x00FF + 0x0001 = 0x0100).
